// File: rtl/serial_rx_pkg.sv
// Purpose : shared types and defaults for the serial bit receiver.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
// Contents: receiver FSM state enum, default bit period, default data width,
//           and a small parity helper.
package serial_rx_pkg;

   // Default clock cycles per serial bit (must be even and at least 4).
   localparam int DEF_BIT_CYCLES = 4;

   // Default number of data bits per frame.
   localparam int DEF_DATA_W = 8;

   // Receiver frame states, in the order a clean frame walks through them.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } rx_state_t;

   // Running even-parity update: fold one received bit into the accumulator.
   function automatic logic par_step(input logic acc, input logic bit_in);
      return acc ^ bit_in;
   endfunction

endpackage

// File: rtl/serial_bit_rx_sync2.sv
// Purpose : two-flop synchronizer for one asynchronous bit, both stages preset to 1.
// Latency : 2 clk cycles from d to q.
// Backpr. : none; free-running, samples every cycle.
// Ports   : clk (clock), rst_n (sync active-low reset, forces both stages to 1),
//           d (async input), q (synchronized output).
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   // First stage may go metastable; only the second stage is used downstream.
   logic meta;

   // Preset to 1 so an idle-high line never shows a false start bit after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/serial_bit_rx.sv
// Purpose : serial frame receiver: start, DATA_W data bits LSB first, even parity, stop.
// Latency : stop sample lands 2 + BIT_CYCLES/2 + (DATA_W+2)*BIT_CYCLES edges after the
//           synchronizer first captures the start bit; VALID is high the cycle after that.
// Backpr. : none; results are one-cycle pulses with held data, the consumer must keep up.
// Ports   : CLK, RST_N (sync active-low), D0 (async serial line, idle high),
//           DATA_OUT (last word), VALID (1-cycle pulse), PAR_ERR, FRM_ERR (flags for the
//           frame marked by VALID), BUSY (frame in progress).
module serial_bit_rx
   import serial_rx_pkg::*;
#(
   parameter int BIT_CYCLES = DEF_BIT_CYCLES,
   parameter int DATA_W     = DEF_DATA_W
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              D0,
   output logic [DATA_W-1:0] DATA_OUT,
   output logic              VALID,
   output logic              PAR_ERR,
   output logic              FRM_ERR,
   output logic              BUSY
);

   localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   // Start bit is sampled half a bit in; every later bit one full bit after the previous.
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYCLES / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   logic              line;     // synchronized serial line
   rx_state_t         state;
   logic [CNT_W-1:0]  cnt;      // cycles into the current bit
   logic [IDX_W-1:0]  idx;      // data bit being received
   logic [DATA_W-1:0] shreg;    // frame assembly register, separate from DATA_OUT
   logic              par_acc;  // XOR of data bits received so far
   logic              par_bad;  // parity verdict, held until the stop sample
   logic              bit_tick; // centre of a data/parity/stop bit

   sync2 u_sync (
      .clk   (CLK),
      .rst_n (RST_N),
      .d     (D0),
      .q     (line)
   );

   assign bit_tick = (cnt == CNT_LAST);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         shreg    <= '0;
         par_acc  <= 1'b0;
         par_bad  <= 1'b0;
         DATA_OUT <= '0;
         VALID    <= 1'b0;
         PAR_ERR  <= 1'b0;
         FRM_ERR  <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         // VALID is a single-cycle strobe; only the stop sample raises it.
         VALID <= 1'b0;

         case (state)
            IDLE: begin
               if (!line) begin
                  state <= START;
                  cnt   <= '0;
                  BUSY  <= 1'b1;
               end
            end

            START: begin
               if (cnt == CNT_HALF) begin
                  cnt <= '0;
                  if (!line) begin
                     state   <= DATA;
                     idx     <= '0;
                     par_acc <= 1'b0;
                  end else begin
                     // Line went back high mid start bit: treat as a glitch.
                     state <= IDLE;
                     BUSY  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (bit_tick) begin
                  cnt        <= '0;
                  // Every bit position is written each frame, so shreg needs no clear.
                  shreg[idx] <= line;
                  par_acc    <= par_step(par_acc, line);
                  if (idx == IDX_LAST) begin
                     state <= PARITY;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            PARITY: begin
               if (bit_tick) begin
                  cnt     <= '0;
                  // Even parity: data XOR parity bit must be 0 for a good frame.
                  par_bad <= par_step(par_acc, line);
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            STOP: begin
               if (bit_tick) begin
                  cnt      <= '0;
                  DATA_OUT <= shreg;
                  PAR_ERR  <= par_bad;
                  FRM_ERR  <= ~line;
                  VALID    <= 1'b1;
                  if (line) begin
                     state <= IDLE;
                     BUSY  <= 1'b0;
                  end else begin
                     // Broken stop bit: wait for the line to idle before hunting again,
                     // otherwise a held-low line would look like endless start bits.
                     state <= WAIT_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            WAIT_IDLE: begin
               if (line) begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_bit_rx.sv
// Purpose : self-checking bench for serial_bit_rx with directed and random frames.
// Latency : expected VALID edge derived from frame timing arithmetic.
// Backpr. : n/a.
module tb_serial_bit_rx;

   localparam int BC  = 4;
   localparam int DW  = 8;
   // VALID is seen high at edge k + LAT, k = edge where sync stage 1 captures the start 0.
   localparam int LAT = 3 + BC / 2 + (DW + 2) * BC;

   logic          CLK   = 1'b0;
   logic          RST_N = 1'b0;
   logic          D0    = 1'b1;
   logic [DW-1:0] DATA_OUT;
   logic          VALID;
   logic          PAR_ERR;
   logic          FRM_ERR;
   logic          BUSY;

   int cyc      = 0;
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic          par;
      logic          frm;
      int            vld_edge;
   } exp_t;

   exp_t exp_q[$];
   int   vld_edges[$];

   serial_bit_rx #(.BIT_CYCLES(BC), .DATA_W(DW)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .D0       (D0),
      .DATA_OUT (DATA_OUT),
      .VALID    (VALID),
      .PAR_ERR  (PAR_ERR),
      .FRM_ERR  (FRM_ERR),
      .BUSY     (BUSY)
   );

   always #5 CLK = ~CLK;

   // cyc holds the index of the most recent rising edge.
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Each VALID cycle is matched against the oldest outstanding frame.
   always @(negedge CLK) begin : mon
      exp_t e;
      if (VALID) begin
         vld_edges.push_back(cyc + 1);
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(VALID), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("data_out",   32'(DATA_OUT), 32'(e.data));
            check("par_err",    32'(PAR_ERR),  32'(e.par));
            check("frm_err",    32'(FRM_ERR),  32'(e.frm));
            check("valid_edge", 32'(cyc + 1),  32'(e.vld_edge));
         end
      end
   end

   // Drive one level for n cycles; always returns 1 time unit after a rising edge.
   task automatic drive_bit(input logic b, input int n);
      D0 = b;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Send a whole frame and record what the receiver should report for it.
   task automatic send_frame(input logic [DW-1:0] data, input logic flip_par, input logic stop_bit);
      exp_t e;
      e.data     = data;
      e.par      = flip_par;
      e.frm      = ~stop_bit;
      e.vld_edge = cyc + 1 + LAT;
      exp_q.push_back(e);
      drive_bit(1'b0, BC);
      for (int i = 0; i < DW; i++) drive_bit(data[i], BC);
      drive_bit((^data) ^ flip_par, BC);
      drive_bit(stop_bit, BC);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int            nv;
      logic [DW-1:0] rdata;
      logic          rflip;
      logic          rstop;

      RST_N = 1'b0;
      D0    = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_data_out", 32'(DATA_OUT), 32'd0);
      check("rst_valid",    32'(VALID),    32'd0);
      check("rst_par_err",  32'(PAR_ERR),  32'd0);
      check("rst_frm_err",  32'(FRM_ERR),  32'd0);
      check("rst_busy",     32'(BUSY),     32'd0);
      RST_N = 1'b1;
      drive_bit(1'b1, 5);

      // Clean frame, then a parity error.
      send_frame(8'hA5, 1'b0, 1'b1);
      drive_bit(1'b1, 10);
      send_frame(8'h3C, 1'b1, 1'b1);
      drive_bit(1'b1, 10);

      // Broken stop bit with the line held low afterwards.
      send_frame(8'h01, 1'b0, 1'b0);
      drive_bit(1'b0, 20);
      check("busy_wait_idle", 32'(BUSY), 32'd1);
      drive_bit(1'b1, 4);
      check("busy_after_idle", 32'(BUSY), 32'd0);
      drive_bit(1'b1, 10);

      // One-cycle low glitch on an idle line.
      nv = vld_edges.size();
      drive_bit(1'b0, 1);
      drive_bit(1'b1, 2);
      check("glitch_busy_hi", 32'(BUSY), 32'd1);
      drive_bit(1'b1, BC / 2);
      check("glitch_busy_lo", 32'(BUSY), 32'd0);
      drive_bit(1'b1, 20);
      check("glitch_no_valid", 32'(vld_edges.size()), 32'(nv));

      // Back-to-back frames with no idle gap.
      nv = vld_edges.size();
      send_frame(8'h55, 1'b0, 1'b1);
      send_frame(8'hAA, 1'b0, 1'b1);
      drive_bit(1'b1, 10);
      check("b2b_count", 32'(vld_edges.size() - nv), 32'd2);
      if (vld_edges.size() >= nv + 2)
         check("b2b_spacing", 32'(vld_edges[nv+1] - vld_edges[nv]), 32'((DW + 3) * BC));

      // Reset in the middle of the data bits aborts the frame.
      nv = vld_edges.size();
      drive_bit(1'b0, BC);
      drive_bit(1'b0, 3 * BC);
      RST_N = 1'b0;
      @(posedge CLK);
      #1;
      check("midrst_busy",     32'(BUSY),     32'd0);
      check("midrst_data_out", 32'(DATA_OUT), 32'd0);
      RST_N = 1'b1;
      drive_bit(1'b1, 20);
      check("midrst_no_valid", 32'(vld_edges.size()), 32'(nv));
      send_frame(8'h7E, 1'b0, 1'b1);
      drive_bit(1'b1, 10);

      // Random frames with occasional parity/stop errors and random gaps.
      for (int i = 0; i < 24; i++) begin
         rdata = DW'($urandom);
         rflip = ($urandom_range(0, 3) == 0);
         rstop = ($urandom_range(0, 4) != 0);
         send_frame(rdata, rflip, rstop);
         if (!rstop) begin
            drive_bit(1'b0, int'($urandom_range(0, 8)));
            drive_bit(1'b1, int'($urandom_range(2, 6)));
         end else begin
            drive_bit(1'b1, int'($urandom_range(0, 5)));
         end
      end
      drive_bit(1'b1, 60);
      check("pending_frames", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
